fetch_stage: RTL and testbench

//  RV32I instruction-fetch stage for the BEAN-2 pipeline, directly upstream of control_logic.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the BEAN-2 instruction-fetch stage.
//   pc_sel_e    : M-stage next-PC select encodings
//   state_e     : fetch FSM states
//   fetch_ent_t : {inst, pc} entry held by the skid buffer
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JALR = 2'b01,
    PC_RSV  = 2'b10,  // reserved, behaves as sequential
    PC_BR   = 2'b11
  } pc_sel_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // ADDI x0,x0,0

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_REQ  = 2'b01,
    S_DROP = 2'b10,
    S_FULL = 2'b11
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_ent_t;

  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == PC_JALR) || (sel == PC_BR);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {inst, pc} while IF/ID is stalled.
//   clk, reset : clock, async active-high reset
//   clr_i      : drop the entry (redirect); wins over push/pop
//   push_i     : capture ent_i
//   pop_i      : release the entry
//   ent_o      : stored entry, full_o : entry valid
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  fetch_ent_t ent_i,
  output fetch_ent_t ent_o,
  output logic       full_o
);

  fetch_ent_t ent_q;
  logic       full_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q  <= '0;
      full_q <= 1'b0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (push_i) begin
      ent_q  <= ent_i;
      full_q <= 1'b1;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign ent_o  = ent_q;
  assign full_o = full_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives a req/ack instruction
// memory port and fills the IF/ID register.
//   clk, reset             : clock, async active-high reset
//   pc_SEL, pc_target_M,
//   alu_out_M              : M-stage redirect select and target operands
//   stall_D, flush_D       : hazard-unit hold / bubble for IF/ID
//   imem_req/addr/ack/rdata: instruction memory handshake
//   inst_D, pc_D, pc4_D,
//   valid_D                : IF/ID register contents
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_SEL,
  input  logic [31:0] pc_target_M,
  input  logic [31:0] alu_out_M,
  input  logic        stall_D,
  input  logic        flush_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        valid_D
);
  import fetch_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;  // address of the request being discarded
  logic [31:0] inst_q, inst_d, pcD_q, pcD_d, pc4D_q, pc4D_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_raw;

  logic        redirect, hold, acc, to_skid, skid_pop, skid_full;
  logic [31:0] target;
  fetch_ent_t  skid_in, skid_out;

  assign redirect = is_redirect(pc_SEL);
  assign target   = (pc_SEL == PC_BR) ? pc_target_M : {alu_out_M[31:1], 1'b0};

  // IF/ID only holds when it actually contains an instruction; an empty
  // register accepts a word even under stall.
  assign hold     = stall_D & valid_q;
  // Only a request issued from S_REQ can be accepted; a redirect kills it.
  assign acc      = (state_q == S_REQ) & imem_ack & ~redirect;
  assign to_skid  = acc & hold;
  // Flush and stall both keep the buffered word; a redirect makes it stale.
  assign skid_pop = skid_full & ~redirect & ~flush_D & ~hold;

  assign skid_in  = '{inst: imem_rdata, pc: pc_q};

  fetch_skid_buf u_skid (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (redirect),
    .push_i (to_skid),
    .pop_i  (skid_pop),
    .ent_i  (skid_in),
    .ent_o  (skid_out),
    .full_o (skid_full)
  );

  // PC: redirect beats everything, otherwise advance once per accepted word.
  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = target;
    else if (acc)  pc_d = pc_q + 32'd4;
  end

  // FSM next state and memory-port outputs.
  always_comb begin
    state_d     = state_q;
    drop_addr_d = drop_addr_q;
    imem_req    = 1'b0;
    addr_raw    = pc_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          // The request cannot be withdrawn: keep presenting it until acked.
          if (!imem_ack) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (to_skid) begin
          state_d = S_FULL;
        end
      end
      S_DROP: begin
        imem_req = 1'b1;
        addr_raw = drop_addr_q;
        if (imem_ack) state_d = S_REQ;
      end
      S_FULL: begin
        if (redirect || skid_pop) state_d = S_REQ;
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign imem_addr = {addr_raw[31:2], 2'b00};

  // IF/ID: flush > stall > skid buffer > new word > bubble.
  always_comb begin
    inst_d  = inst_q;
    pcD_d   = pcD_q;
    pc4D_d  = pc4D_q;
    valid_d = valid_q;
    if (flush_D) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (hold) begin
      // keep current contents
    end else if (skid_pop) begin
      inst_d  = skid_out.inst;
      pcD_d   = skid_out.pc;
      pc4D_d  = skid_out.pc + 32'd4;
      valid_d = 1'b1;
    end else if (acc) begin
      inst_d  = imem_rdata;
      pcD_d   = pc_q;
      pc4D_d  = pc_q + 32'd4;
      valid_d = 1'b1;
    end else begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_VECTOR;
      drop_addr_q <= '0;
      inst_q      <= NOP_INST;
      pcD_q       <= '0;
      pc4D_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      inst_q      <= inst_d;
      pcD_q       <= pcD_d;
      pc4D_q      <= pc4D_d;
      valid_q     <= valid_d;
    end
  end

  assign inst_D  = inst_q;
  assign pc_D    = pcD_q;
  assign pc4_D   = pc4D_q;
  assign valid_D = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pc_SEL = 2'b00;
  logic [31:0] pc_target_M = '0, alu_out_M = '0;
  logic        stall_D = 1'b0, flush_D = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] inst_D, pc_D, pc4_D;
  logic        valid_D;

  int checks = 0, errors = 0, row = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_VECTOR(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .pc_SEL(pc_SEL), .pc_target_M(pc_target_M),
    .alu_out_M(alu_out_M), .stall_D(stall_D), .flush_D(flush_D),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_D(inst_D), .pc_D(pc_D), .pc4_D(pc4_D),
    .valid_D(valid_D)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] tgt, alu;
    logic        stall, flush, ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst, e_pc;
  } vec_t;

  function automatic logic [31:0] D(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  function automatic vec_t v(input logic [1:0] sel, input logic [31:0] tgt, alu,
                             input logic stall, flush, ack, input logic [31:0] rdata,
                             input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] inst, pc);
    vec_t r;
    r.sel = sel; r.tgt = tgt; r.alu = alu; r.stall = stall; r.flush = flush;
    r.ack = ack; r.rdata = rdata; r.e_req = req; r.e_addr = addr;
    r.e_valid = valid; r.e_inst = inst; r.e_pc = pc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and check the outputs of
  // that cycle before the next rising edge.
  task automatic step(input vec_t t);
    @(negedge clk);
    pc_SEL = t.sel; pc_target_M = t.tgt; alu_out_M = t.alu;
    stall_D = t.stall; flush_D = t.flush; imem_ack = t.ack; imem_rdata = t.rdata;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, t.e_req});
    if (t.e_req) chk("imem_addr", imem_addr, t.e_addr);
    chk("valid_D", {31'd0, valid_D}, {31'd0, t.e_valid});
    chk("inst_D", inst_D, t.e_inst);
    chk("pc_D", pc_D, t.e_pc);
    if (t.e_valid) chk("pc4_D", pc4_D, t.e_pc + 32'd4);
    row++;
  endtask

  task automatic chk_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid_D}, 32'd0);
    chk("rst_inst", inst_D, NOP);
    chk("rst_pc", pc_D, 32'd0);
    chk("rst_pc4", pc4_D, 32'd0);
  endtask

  vec_t tbl[30];

  initial begin
    // sel tgt alu stall flush ack rdata | req addr valid inst pc
    // 1-cycle memory: 0,4,8 back to back
    tbl[0]  = v(0, 0, 0, 0, 0, 0, 0,          0, 32'h0,   0, NOP,          32'h0);
    tbl[1]  = v(0, 0, 0, 0, 0, 1, D(32'h0),   1, 32'h0,   0, NOP,          32'h0);
    tbl[2]  = v(0, 0, 0, 0, 0, 1, D(32'h4),   1, 32'h4,   1, D(32'h0),     32'h0);
    tbl[3]  = v(0, 0, 0, 0, 0, 1, D(32'h8),   1, 32'h8,   1, D(32'h4),     32'h4);
    // 3-cycle latency: address held, bubbles between deliveries
    tbl[4]  = v(0, 0, 0, 0, 0, 0, 0,          1, 32'hC,   1, D(32'h8),     32'h8);
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 0,          1, 32'hC,   0, NOP,          32'h8);
    tbl[6]  = v(0, 0, 0, 0, 0, 1, D(32'hC),   1, 32'hC,   0, NOP,          32'h8);
    tbl[7]  = v(0, 0, 0, 0, 0, 0, 0,          1, 32'h10,  1, D(32'hC),     32'hC);
    tbl[8]  = v(0, 0, 0, 0, 0, 1, D(32'h10),  1, 32'h10,  0, NOP,          32'hC);
    // 4-cycle stall: one word skids, request stops, released in order
    tbl[9]  = v(0, 0, 0, 1, 0, 1, D(32'h14),  1, 32'h14,  1, D(32'h10),    32'h10);
    tbl[10] = v(0, 0, 0, 1, 0, 0, 0,          0, 32'h18,  1, D(32'h10),    32'h10);
    tbl[11] = v(0, 0, 0, 1, 0, 0, 0,          0, 32'h18,  1, D(32'h10),    32'h10);
    tbl[12] = v(0, 0, 0, 1, 0, 0, 0,          0, 32'h18,  1, D(32'h10),    32'h10);
    tbl[13] = v(0, 0, 0, 0, 0, 0, 0,          0, 32'h18,  1, D(32'h10),    32'h10);
    tbl[14] = v(0, 0, 0, 0, 0, 1, D(32'h18),  1, 32'h18,  1, D(32'h14),    32'h14);
    tbl[15] = v(0, 0, 0, 0, 0, 0, 0,          1, 32'h1C,  1, D(32'h18),    32'h18);
    tbl[16] = v(0, 0, 0, 0, 0, 1, D(32'h1C),  1, 32'h1C,  0, NOP,          32'h18);
    // branch to 0x100 while 0x20 outstanding: 0x20 data dropped
    tbl[17] = v(3, 32'h100, 0, 0, 0, 0, 0,    1, 32'h20,  1, D(32'h1C),    32'h1C);
    tbl[18] = v(0, 0, 0, 0, 0, 0, 0,          1, 32'h20,  0, NOP,          32'h1C);
    tbl[19] = v(0, 0, 0, 0, 0, 1, D(32'h20),  1, 32'h20,  0, NOP,          32'h1C);
    tbl[20] = v(0, 0, 0, 0, 0, 0, 0,          1, 32'h100, 0, NOP,          32'h1C);
    tbl[21] = v(0, 0, 0, 0, 0, 1, D(32'h100), 1, 32'h100, 0, NOP,          32'h1C);
    // JALR to 0x205 (-> 0x204) with same-cycle flush
    tbl[22] = v(1, 0, 32'h205, 0, 1, 0, 0,    1, 32'h104, 1, D(32'h100),   32'h100);
    tbl[23] = v(0, 0, 0, 0, 0, 1, D(32'h104), 1, 32'h104, 0, NOP,          32'h100);
    tbl[24] = v(0, 0, 0, 0, 0, 1, D(32'h204), 1, 32'h204, 0, NOP,          32'h100);
    tbl[25] = v(0, 0, 0, 0, 0, 0, 0,          1, 32'h208, 1, D(32'h204),   32'h204);
    // redirect with same-cycle ack: ack discarded, next address is target
    tbl[26] = v(3, 32'h300, 0, 0, 0, 1, D(32'h208), 1, 32'h208, 0, NOP,    32'h204);
    // reserved select behaves as sequential
    tbl[27] = v(2, 32'h500, 32'h501, 0, 0, 0, 0, 1, 32'h300, 0, NOP,       32'h204);
    tbl[28] = v(2, 32'h500, 32'h501, 0, 0, 1, D(32'h300), 1, 32'h300, 0, NOP, 32'h204);
    tbl[29] = v(0, 0, 0, 0, 0, 0, 0,          1, 32'h304, 1, D(32'h300),   32'h300);

    @(negedge clk); #1;
    chk_reset();
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 30; i++) step(tbl[i]);

    // Reset while the request to 0x304 is pending; ack lands in S_BOOT.
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; #1;
    chk_reset();
    @(posedge clk); #1 reset = 1'b0;
    step(v(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, NOP, 32'h0));
    step(v(0, 0, 0, 0, 0, 0, 0,             1, 32'h0, 0, NOP, 32'h0));
    step(v(0, 0, 0, 0, 0, 1, D(32'h0),      1, 32'h0, 0, NOP, 32'h0));
    // Branch to the top word, then PC wraps to zero.
    step(v(3, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h0BAD_0BAD, 1, 32'h4, 1, D(32'h0), 32'h0));
    step(v(0, 0, 0, 0, 0, 1, 32'h1234_5678, 1, 32'hFFFF_FFFC, 0, NOP, 32'h0));
    step(v(0, 0, 0, 0, 0, 0, 0,             1, 32'h0, 1, 32'h1234_5678, 32'hFFFF_FFFC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
